// File: rtl/pair_serializer_fifo_pkg.sv
// Shared defaults and FSM state encodings for the pair serializer FIFO.
// Imported by the storage sub-module and by the top.
package pair_serializer_fifo_pkg;

    localparam int unsigned DWIDTH_DEF       = 16;
    localparam int unsigned SAMPLES_PER_WORD = 2;
    localparam int unsigned FIFO_DEPTH_DEF   = 4;

    // Input-side four-phase handshake FSM
    localparam int unsigned IN_STATE_W = 1;
    localparam logic [IN_STATE_W-1:0] IN_IDLE = 1'b0;
    localparam logic [IN_STATE_W-1:0] IN_ACK  = 1'b1;

    // Output-side four-phase handshake FSM
    localparam int unsigned OUT_STATE_W = 2;
    localparam logic [OUT_STATE_W-1:0] OUT_IDLE = 2'd0;
    localparam logic [OUT_STATE_W-1:0] OUT_REQ  = 2'd1;
    localparam logic [OUT_STATE_W-1:0] OUT_WAIT = 2'd2;

endpackage

// File: rtl/pair_serializer_fifo_fifo.sv
// Word storage for the pair serializer: synchronous FIFO with registered level.
// Push is refused when full and pop when empty, so level cannot leave [0, DEPTH].
module pair_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [0:WIDTH-1]         wdata_i,
    input  logic                     pop_i,
    output logic [0:WIDTH-1]         head_c,
    output logic                     full_c,
    output logic                     empty_c,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [0:WIDTH-1] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_c  = (level_q == LVL_W'(DEPTH));
    assign empty_c = (level_q == LVL_W'(0));
    assign do_push = push_i & ~full_c;
    assign do_pop  = pop_i & ~empty_c;
    assign head_c  = mem_q[head_q];
    assign level_o = level_q;

    // Pointer and level next-state; power-of-two depth makes pointers wrap for free
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        if (do_push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        if (do_pop) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
        end
    end

    // Storage array needs no reset: contents are only visible behind level
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[tail_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/pair_serializer_fifo.sv
// Accepts two-sample words over a four-phase handshake, buffers them in a FIFO and
// emits the samples one at a time (a0 then a1) over a second four-phase handshake.
module pair_serializer_fifo
    import pair_serializer_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH  = DWIDTH_DEF,
    parameter int unsigned DDWIDTH = SAMPLES_PER_WORD * DWIDTH,
    parameter int unsigned DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_in,
    output logic                    ack_in,
    input  logic [0:DDWIDTH-1]      data_in,
    output logic                    req_out,
    input  logic                    ack_out,
    output logic [0:DWIDTH-1]       data_out,
    output logic [$clog2(DEPTH):0]  level
);

    logic [IN_STATE_W-1:0]  in_q, in_d;
    logic [OUT_STATE_W-1:0] out_q, out_d;
    logic                   ack_q, ack_d;
    logic                   req_q, req_d;
    logic                   half_q, half_d;
    logic [0:DWIDTH-1]      dout_q, dout_d;

    logic                   push_c;
    logic                   pop_c;
    logic [0:DDWIDTH-1]     head_c;
    logic                   full_c;
    logic                   empty_c;

    pair_fifo #(
        .WIDTH (DDWIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .wdata_i (data_in),
        .pop_i   (pop_c),
        .head_c  (head_c),
        .full_c  (full_c),
        .empty_c (empty_c),
        .level_o (level)
    );

    // Input handshake: one write per req_in high phase, gated by the registered full flag
    always_comb begin
        in_d   = in_q;
        ack_d  = ack_q;
        push_c = 1'b0;
        case (in_q)
            IN_IDLE: begin
                if (req_in && !full_c) begin
                    push_c = 1'b1;
                    ack_d  = 1'b1;
                    in_d   = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!req_in) begin
                    ack_d = 1'b0;
                    in_d  = IN_IDLE;
                end
            end
            default: begin
                ack_d = 1'b0;
                in_d  = IN_IDLE;
            end
        endcase
    end

    // Output serializer: present the half-selected sample, pop only after a1 is taken
    always_comb begin
        out_d  = out_q;
        req_d  = req_q;
        half_d = half_q;
        dout_d = dout_q;
        pop_c  = 1'b0;
        case (out_q)
            OUT_IDLE: begin
                if (!empty_c) begin
                    dout_d = half_q ? head_c[DWIDTH:DDWIDTH-1] : head_c[0:DWIDTH-1];
                    req_d  = 1'b1;
                    out_d  = OUT_REQ;
                end
            end
            OUT_REQ: begin
                if (ack_out) begin
                    req_d  = 1'b0;
                    pop_c  = half_q;
                    half_d = ~half_q;
                    out_d  = OUT_WAIT;
                end
            end
            OUT_WAIT: begin
                if (!ack_out) begin
                    out_d = OUT_IDLE;
                end
            end
            default: begin
                req_d = 1'b0;
                out_d = OUT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_q   <= IN_IDLE;
            out_q  <= OUT_IDLE;
            ack_q  <= 1'b0;
            req_q  <= 1'b0;
            half_q <= 1'b0;
            dout_q <= '0;
        end else begin
            in_q   <= in_d;
            out_q  <= out_d;
            ack_q  <= ack_d;
            req_q  <= req_d;
            half_q <= half_d;
            dout_q <= dout_d;
        end
    end

    assign ack_in   = ack_q;
    assign req_out  = req_q;
    assign data_out = dout_q;

endmodule

// File: doc/pair_serializer_fifo.md
PAIR_SERIALIZER_FIFO -- requirements
Module: pair_serializer_fifo

Interface
REQ-001 Parameter DWIDTH, default 16: bits per sample.
REQ-002 Parameter DDWIDTH, default 2*DWIDTH: bits per input word (two samples).
REQ-003 Parameter DEPTH, default 4: FIFO capacity in words; power of two, at least 2.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_in  input  1  upstream (filter output side) offers a word; four-phase.
REQ-007 ack_in  output  1  word accepted.
REQ-008 data_in  input  [0:DDWIDTH-1]  sample pair; a0 = bits [0:DWIDTH-1], a1 = bits [DWIDTH:DDWIDTH-1]; stable while req_in high.
REQ-009 req_out  output  1  single sample valid on data_out; four-phase.
REQ-010 ack_out  input  1  downstream has taken the sample.
REQ-011 data_out  output  [0:DWIDTH-1]  current sample, held stable while req_out high.
REQ-012 level  output  clog2(DEPTH)+1  number of words stored, including any word in the middle of serialization.

Function
REQ-013 Input FSM states: IN_IDLE, IN_ACK.
REQ-014 IN_IDLE with req_in=1 and registered level<DEPTH: write data_in at tail, ack_in<=1, go to IN_ACK.
REQ-015 IN_IDLE with req_in=1 and level==DEPTH: hold ack_in=0; do not write; stay in IN_IDLE until space exists.
REQ-016 IN_ACK with req_in=0: ack_in<=0, go to IN_IDLE; with req_in=1 stay; a word is written once per handshake only.
REQ-017 Full check uses registered level; a pop in the same cycle does not free space for that cycle's push.
REQ-018 Output FSM states: OUT_IDLE, OUT_REQ, OUT_WAIT; internal half flag selects a0 (0) or a1 (1).
REQ-019 OUT_IDLE with level>0: data_out<=head sample selected by half, req_out<=1, go to OUT_REQ.
REQ-020 OUT_REQ with ack_out=1: req_out<=0; if half=1 pop head and half<=0, else half<=1; go to OUT_WAIT.
REQ-021 OUT_WAIT with ack_out=0: go to OUT_IDLE; with ack_out=1 stay.
REQ-022 Output order per word: a0 then a1; words leave in arrival order.
REQ-023 Latency: word written at edge k gives req_out=1 no earlier than after edge k+1 when the FIFO was empty and OUT_IDLE.
REQ-024 Simultaneous push and pop in one cycle: both take effect; level unchanged.
REQ-025 Head/tail pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH; level saturates by construction, never exceeds DEPTH nor underflows.
REQ-026 No data path arithmetic; samples pass bit-exact, signedness irrelevant.
REQ-027 data_out changes only on the OUT_IDLE to OUT_REQ transition.

Reset
REQ-028 On rst: ack_in=0, req_out=0, data_out=0, level=0, pointers=0, half=0, both FSMs idle.
REQ-029 rst mid-handshake discards all stored words and any partially serialized word; no glitch or extra ack is produced after release.
REQ-030 First handshake after reset is accepted no earlier than the cycle following rst deassertion.

Structure
REQ-031 Shared package holds DWIDTH/DDWIDTH defaults and the input and output FSM state encodings.
REQ-032 Storage is one sub-module, pair_fifo (synchronous, registered level, push/pop/head/full/empty); the two FSMs and the serializer live in the top.

Verification
REQ-033 Single word 0x1234ABCD, sink acks each req in 1 cycle -> data_out 0x1234 then 0xABCD, level returns to 0.
REQ-034 Five words pushed, sink stalled -> level reaches 4, fifth req_in not acked until first a1 handshake completes; order preserved.
REQ-035 Continuous source and sink, 64 random words -> 128 samples out, bit-exact, in order, pointer wrap exercised.
REQ-036 Push at the cycle of a pop with level=2 -> level stays 2, both words intact.
REQ-037 rst asserted while req_out=1 after a0 of 0xFFFF0001 sent -> req_out=0, level=0; the 0x0001 sample is never emitted.
REQ-038 Sink holds ack_out high 5 cycles -> no new req_out until ack_out falls; data_out stable throughout.
